// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared opcodes, forwarding encodings and shadow types for hazard_ctrl
package hazard_pkg;

    // RV32I major opcodes (instruction[6:0])
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // EX operand source selects
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // Register usage of the instruction sitting in EX
    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       wr;
        logic       load;
    } ex_shadow_t;

    // Destination of the instructions in MEM and WB
    typedef struct packed {
        logic [4:0] rd;
        logic       wr;
    } rd_shadow_t;

    // MEM result is younger than WB, so it wins when both match
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input rd_shadow_t mem,
                                           input rd_shadow_t wb);
        if (mem.wr && (mem.rd == rs)) begin
            return FWD_MEM;
        end else if (wb.wr && (wb.rd == rs)) begin
            return FWD_WB;
        end
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_decode.sv
// rtl/hazard_decode.sv - register usage decode of the IF/ID instruction
module hazard_decode
    import hazard_pkg::*;
(
    input  logic [31:0] instruction,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        writes_rd,
    output logic        is_load
);

    logic [6:0] opcode;
    logic       rd_op;
    logic       unused_bits;

    assign opcode      = instruction[6:0];
    assign unused_bits = ^{instruction[31:25], instruction[14:12]};

    // Classify the opcode into source/destination usage
    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        rd_op    = 1'b0;
        is_load  = 1'b0;
        case (opcode)
            OPC_LOAD: begin
                uses_rs1 = 1'b1;
                rd_op    = 1'b1;
                is_load  = 1'b1;
            end
            OPC_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_OP: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                rd_op    = 1'b1;
            end
            OPC_OP_IMM: begin
                uses_rs1 = 1'b1;
                rd_op    = 1'b1;
            end
            OPC_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_JAL: begin
                rd_op    = 1'b1;
            end
            OPC_JALR: begin
                uses_rs1 = 1'b1;
                rd_op    = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                rd_op    = 1'b1;
            end
            default: begin
                uses_rs1 = 1'b0;
            end
        endcase
    end

    // Unused source fields read as x0 so immediate bits never look like a match downstream
    assign rs1       = uses_rs1 ? instruction[19:15] : 5'd0;
    assign rs2       = uses_rs2 ? instruction[24:20] : 5'd0;
    assign rd        = instruction[11:7];
    // x0 is never a real destination
    assign writes_rd = rd_op & (instruction[11:7] != 5'd0);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/forwarding control with shadow pipeline and perf counters
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       instruction_d,
    input  logic              pc_src_e,
    input  logic              ext_stall,
    output logic              stall_f,
    output logic              flush_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_events
);

    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rd_d;
    logic       uses_rs1_d;
    logic       uses_rs2_d;
    logic       writes_rd_d;
    logic       is_load_d;

    ex_shadow_t ex_q;
    ex_shadow_t ex_next;
    rd_shadow_t mem_q;
    rd_shadow_t wb_q;

    logic       load_use;
    logic       stall_inc;

    hazard_decode u_decode (
        .instruction (instruction_d),
        .rs1         (rs1_d),
        .rs2         (rs2_d),
        .rd          (rd_d),
        .uses_rs1    (uses_rs1_d),
        .uses_rs2    (uses_rs2_d),
        .writes_rd   (writes_rd_d),
        .is_load     (is_load_d)
    );

    // A load in EX whose destination the D instruction reads needs one bubble
    assign load_use = ex_q.load & ex_q.wr &
                      ((uses_rs1_d & (rs1_d == ex_q.rd)) |
                       (uses_rs2_d & (rs2_d == ex_q.rd)));

    // Redirect beats load-use; a memory stall freezes everything and defers flushes
    assign stall_d = ext_stall;
    assign stall_f = ext_stall | (load_use & ~pc_src_e);
    assign flush_f = ~ext_stall & pc_src_e;
    assign flush_d = ~ext_stall & (pc_src_e | load_use);

    assign forward_a_e = fwd_sel(ex_q.rs1, mem_q, wb_q);
    assign forward_b_e = fwd_sel(ex_q.rs2, mem_q, wb_q);

    assign stall_inc = load_use & ~pc_src_e & ~ext_stall;

    // Next EX shadow: the decoded D instruction, or a bubble when ID/EX is flushed
    always_comb begin
        ex_next = '0;
        if (!flush_d) begin
            ex_next.rs1  = rs1_d;
            ex_next.rs2  = rs2_d;
            ex_next.rd   = rd_d;
            ex_next.wr   = writes_rd_d;
            ex_next.load = is_load_d;
        end
    end

    // Shadow pipeline advances in lockstep with the real one unless memory stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!ext_stall) begin
            ex_q     <= ex_next;
            mem_q.rd <= ex_q.rd;
            mem_q.wr <= ex_q.wr;
            wb_q     <= mem_q;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_inc && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (flush_f && (flush_events != {CNT_W{1'b1}})) begin
                flush_events <= flush_events + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed table-driven bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_d;
    logic        pc_src_e;
    logic        ext_stall;

    logic        stall_f_a, flush_f_a, stall_d_a, flush_d_a;
    logic [1:0]  fwd_a_a, fwd_b_a;
    logic [15:0] sc_a, fe_a;

    logic        stall_f_b, flush_f_b, stall_d_b, flush_d_b;
    logic [1:0]  fwd_a_b, fwd_b_b;
    logic [1:0]  sc_b, fe_b;

    logic [7:0]  haz_a, haz_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] instr;
        logic        pc_src;
        logic        xstall;
        logic [7:0]  exp_haz;
        logic [15:0] exp_sc;
        logic [15:0] exp_fe;
    } vec_t;

    vec_t vecs [10];

    hazard_ctrl dut_a (
        .clk           (clk),
        .reset         (reset),
        .instruction_d (instruction_d),
        .pc_src_e      (pc_src_e),
        .ext_stall     (ext_stall),
        .stall_f       (stall_f_a),
        .flush_f       (flush_f_a),
        .stall_d       (stall_d_a),
        .flush_d       (flush_d_a),
        .forward_a_e   (fwd_a_a),
        .forward_b_e   (fwd_b_a),
        .stall_cycles  (sc_a),
        .flush_events  (fe_a)
    );

    hazard_ctrl #(.CNT_W(2)) dut_b (
        .clk           (clk),
        .reset         (reset),
        .instruction_d (instruction_d),
        .pc_src_e      (pc_src_e),
        .ext_stall     (ext_stall),
        .stall_f       (stall_f_b),
        .flush_f       (flush_f_b),
        .stall_d       (stall_d_b),
        .flush_d       (flush_d_b),
        .forward_a_e   (fwd_a_b),
        .forward_b_e   (fwd_b_b),
        .stall_cycles  (sc_b),
        .flush_events  (fe_b)
    );

    assign haz_a = {stall_f_a, flush_f_a, stall_d_a, flush_d_a, fwd_a_a, fwd_b_a};
    assign haz_b = {stall_f_b, flush_f_b, stall_d_b, flush_d_b, fwd_a_b, fwd_b_b};

    always #5 clk = ~clk;

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rd,
                                           input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] lw(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [7:0] hz(input logic sf, input logic ff, input logic sd,
                                      input logic fd, input logic [1:0] fa, input logic [1:0] fb);
        return {sf, ff, sd, fd, fa, fb};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ins, input logic pc, input logic xs);
        instruction_d = ins;
        pc_src_e      = pc;
        ext_stall     = xs;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        instruction_d = NOP;
        pc_src_e      = 1'b0;
        ext_stall     = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b1;
        instruction_d = NOP;
        pc_src_e      = 1'b0;
        ext_stall     = 1'b0;
        #7;
        chk("reset_haz_a", 32'(haz_a), 32'h0);
        chk("reset_haz_b", 32'(haz_b), 32'h0);
        chk("reset_sc_a",  32'(sc_a),  32'h0);
        chk("reset_fe_a",  32'(fe_a),  32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // One vector per cycle from a clean pipeline: load-use, WB/MEM forwarding,
        // redirect over load-use, and x0 destination
        vecs[0] = '{lw(5, 1),                    1'b0, 1'b0, hz(0,0,0,0,2'b00,2'b00), 16'd0, 16'd0};
        vecs[1] = '{r_type(7'd0, 6, 5, 2),       1'b0, 1'b0, hz(1,0,0,1,2'b00,2'b00), 16'd0, 16'd0};
        vecs[2] = '{r_type(7'd0, 6, 5, 2),       1'b0, 1'b0, hz(0,0,0,0,2'b00,2'b00), 16'd1, 16'd0};
        vecs[3] = '{r_type(7'd0, 3, 1, 2),       1'b0, 1'b0, hz(0,0,0,0,2'b01,2'b00), 16'd1, 16'd0};
        vecs[4] = '{r_type(7'b0100000, 4, 3, 3), 1'b0, 1'b0, hz(0,0,0,0,2'b00,2'b00), 16'd1, 16'd0};
        vecs[5] = '{lw(5, 1),                    1'b0, 1'b0, hz(0,0,0,0,2'b10,2'b10), 16'd1, 16'd0};
        vecs[6] = '{r_type(7'd0, 6, 5, 2),       1'b1, 1'b0, hz(0,1,0,1,2'b00,2'b00), 16'd1, 16'd0};
        vecs[7] = '{lw(0, 1),                    1'b0, 1'b0, hz(0,0,0,0,2'b00,2'b00), 16'd1, 16'd1};
        vecs[8] = '{r_type(7'd0, 6, 0, 0),       1'b0, 1'b0, hz(0,0,0,0,2'b00,2'b00), 16'd1, 16'd1};
        vecs[9] = '{NOP,                         1'b0, 1'b0, hz(0,0,0,0,2'b00,2'b00), 16'd1, 16'd1};

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].instr, vecs[i].pc_src, vecs[i].xstall);
            chk($sformatf("vec%0d_haz", i), 32'(haz_a), 32'(vecs[i].exp_haz));
            chk($sformatf("vec%0d_sc", i),  32'(sc_a),  32'(vecs[i].exp_sc));
            chk($sformatf("vec%0d_fe", i),  32'(fe_a),  32'(vecs[i].exp_fe));
            step();
        end

        // Memory stall holding a pending redirect for three cycles
        apply_reset();
        drive(r_type(7'd0, 3, 1, 2), 1'b0, 1'b0);
        step();
        drive(r_type(7'b0100000, 4, 3, 3), 1'b0, 1'b0);
        step();
        for (int k = 0; k < 3; k++) begin
            drive(NOP, 1'b1, 1'b1);
            chk($sformatf("xstall%0d_haz", k), 32'(haz_a), 32'(hz(1,0,1,0,2'b10,2'b10)));
            step();
        end
        chk("xstall_fe", 32'(fe_a), 32'h0);
        drive(NOP, 1'b1, 1'b0);
        chk("xstall_release_haz", 32'(haz_a), 32'(hz(0,1,0,1,2'b10,2'b10)));
        step();
        drive(NOP, 1'b0, 1'b0);
        chk("xstall_release_fe", 32'(fe_a), 32'h1);
        chk("xstall_release_fwd", 32'(haz_a), 32'(hz(0,0,0,0,2'b00,2'b00)));
        step();

        // Counter saturation on the narrow instance, then reset in the middle of a stall
        apply_reset();
        for (int n = 0; n < 5; n++) begin
            drive(lw(5, 1), 1'b0, 1'b0);
            step();
            drive(r_type(7'd0, 6, 5, 2), 1'b0, 1'b0);
            chk($sformatf("lu%0d_haz", n), 32'(haz_a), 32'(hz(1,0,0,1,2'b00,2'b00)));
            step();
            drive(NOP, 1'b0, 1'b0);
            step();
        end
        chk("sat_sc_a", 32'(sc_a), 32'd5);
        chk("sat_sc_b", 32'(sc_b), 32'd3);
        chk("sat_fe_b", 32'(fe_b), 32'd0);

        drive(lw(5, 1), 1'b0, 1'b0);
        step();
        drive(r_type(7'd0, 6, 5, 2), 1'b0, 1'b0);
        chk("midstall_haz_b", 32'(haz_b), 32'(hz(1,0,0,1,2'b00,2'b00)));
        reset = 1'b1;
        #1;
        chk("midreset_haz_a", 32'(haz_a), 32'h0);
        chk("midreset_haz_b", 32'(haz_b), 32'h0);
        chk("midreset_sc_a",  32'(sc_a),  32'h0);
        chk("midreset_sc_b",  32'(sc_b),  32'h0);
        #1;
        reset = 1'b0;
        drive(NOP, 1'b0, 1'b0);
        step();

        for (int n = 0; n < 4; n++) begin
            drive(NOP, 1'b1, 1'b0);
            step();
        end
        drive(NOP, 1'b0, 1'b0);
        chk("sat_fe_a", 32'(fe_a), 32'd4);
        chk("sat_fe_b2", 32'(fe_b), 32'd3);
        chk("flush_sc_b", 32'(sc_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
